// File: rtl/floor_request_dispatcher.sv
// rtl/floor_request_dispatcher.sv - SCAN-ordered floor call dispatcher; CALL_CANCEL_EN lets a re-press cancel a lit call
module floor_request_dispatcher #(
  parameter int NUM_FLOORS = 10,
  parameter int FLOOR_W    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [FLOOR_W-1:0]    car_floor,
  input  logic                  door_open,
  input  logic                  rescue,
  input  logic                  over_weight,
  output logic [FLOOR_W-1:0]    requested_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  dir_down,
  output logic                  idle,
  output logic                  call_served,
  output logic [FLOOR_W-1:0]    served_floor
);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_HOLD} state_t;

  state_t                state_q, state_d;
  logic [NUM_FLOORS-1:0] btn_q, btn_d;
  logic                  door_q, door_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [FLOOR_W-1:0]    req_q, req_d;
  logic                  dir_up_q, dir_up_d;
  logic                  dir_down_q, dir_down_d;
  logic                  idle_q, idle_d;
  logic                  served_q, served_d;
  logic [FLOOR_W-1:0]    served_floor_q, served_floor_d;

  int                    car_i;
  logic                  pend_at_car, any_above, any_below, any_ge, any_le;
  logic [FLOOR_W-1:0]    lowest_ge, highest_le;
  logic [NUM_FLOORS-1:0] btn_rise, clr_mask;
  logic                  door_rise, freeze;

  // Pending-call search relative to the car; out-of-range car_floor matches no floor.
  always_comb begin
    car_i       = 32'(car_floor);
    pend_at_car = 1'b0;
    any_above   = 1'b0;
    any_below   = 1'b0;
    any_ge      = 1'b0;
    any_le      = 1'b0;
    lowest_ge   = '0;
    highest_le  = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending_q[i] && i >= car_i) begin
        any_ge    = 1'b1;
        lowest_ge = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_q[i] && i <= car_i) begin
        any_le     = 1'b1;
        highest_le = FLOOR_W'(i);
      end
      if (pending_q[i] && i > car_i)  any_above   = 1'b1;
      if (pending_q[i] && i < car_i)  any_below   = 1'b1;
      if (pending_q[i] && i == car_i) pend_at_car = 1'b1;
    end
  end

  always_comb begin
    btn_d     = call_btn;
    door_d    = door_open;
    btn_rise  = call_btn & ~btn_q;
    door_rise = door_open & ~door_q;
    freeze    = rescue | over_weight;
    clr_mask  = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      clr_mask[i] = door_rise && (i == car_i);
    end
`ifdef CALL_CANCEL_EN
    pending_d = (pending_q ^ btn_rise) & ~clr_mask;
`else
    pending_d = (pending_q | btn_rise) & ~clr_mask;
`endif
    served_d       = door_rise && pend_at_car;
    served_floor_d = served_d ? car_floor : served_floor_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      btn_q          <= '0;
      door_q         <= 1'b0;
      pending_q      <= '0;
      req_q          <= '0;
      dir_up_q       <= 1'b0;
      dir_down_q     <= 1'b0;
      idle_q         <= 1'b1;
      served_q       <= 1'b0;
      served_floor_q <= '0;
    end else begin
      state_q        <= state_d;
      btn_q          <= btn_d;
      door_q         <= door_d;
      pending_q      <= pending_d;
      req_q          <= req_d;
      dir_up_q       <= dir_up_d;
      dir_down_q     <= dir_down_d;
      idle_q         <= idle_d;
      served_q       <= served_d;
      served_floor_q <= served_floor_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (freeze) begin
      state_d = S_HOLD;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pend_at_car)    state_d = S_IDLE;
          else if (any_above) state_d = S_UP;
          else if (any_below) state_d = S_DOWN;
        end
        S_UP:    if (!any_ge) state_d = any_below ? S_DOWN : S_IDLE;
        S_DOWN:  if (!any_le) state_d = any_above ? S_UP : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Target follows the state being entered; HOLD and the no-call case park at the car.
  always_comb begin
    req_d = car_floor;
    if (!freeze) begin
      case (state_q)
        S_IDLE: begin
          if (!pend_at_car) begin
            if (any_above)      req_d = lowest_ge;
            else if (any_below) req_d = highest_le;
          end
        end
        S_UP: begin
          if (any_ge)         req_d = lowest_ge;
          else if (any_below) req_d = highest_le;
        end
        S_DOWN: begin
          if (any_le)         req_d = highest_le;
          else if (any_above) req_d = lowest_ge;
        end
        default: req_d = car_floor;
      endcase
    end
    dir_up_d   = (state_d == S_UP);
    dir_down_d = (state_d == S_DOWN);
    idle_d     = (state_d == S_IDLE) && (pending_d == '0);
  end

  assign requested_floor = req_q;
  assign pending         = pending_q;
  assign dir_up          = dir_up_q;
  assign dir_down        = dir_down_q;
  assign idle            = idle_q;
  assign call_served     = served_q;
  assign served_floor    = served_floor_q;

endmodule

// File: tb/tb_floor_request_dispatcher.sv
// tb/tb_floor_request_dispatcher.sv - self-checking bench for floor_request_dispatcher
module tb_floor_request_dispatcher;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] call_btn;
  logic [3:0] car_floor;
  logic       door_open, rescue, over_weight;
  logic [3:0] requested_floor, served_floor;
  logic [9:0] pending;
  logic       dir_up, dir_down, idle, call_served;

  int n_compared = 0;
  int n_mismatch = 0;
  logic [3:0] sb_q[$];
  logic [3:0] exp_floor;

  floor_request_dispatcher #(.NUM_FLOORS(10), .FLOOR_W(4)) dut (
    .clk(clk), .reset(reset), .call_btn(call_btn), .car_floor(car_floor),
    .door_open(door_open), .rescue(rescue), .over_weight(over_weight),
    .requested_floor(requested_floor), .pending(pending), .dir_up(dir_up),
    .dir_down(dir_down), .idle(idle), .call_served(call_served),
    .served_floor(served_floor)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Scoreboard: every call_served pulse must match the next expected served floor.
  always @(negedge clk) begin
    if (reset && call_served) begin
      n_compared++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_served: served_floor %0d with no served call expected", served_floor);
        n_mismatch++;
      end else begin
        exp_floor = sb_q.pop_front();
        if (served_floor !== exp_floor) begin
          $display("FAIL served_floor: got %0d expected %0d", served_floor, exp_floor);
          n_mismatch++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int f);
    call_btn[f] = 1'b1;
    step();
    call_btn[f] = 1'b0;
  endtask

  task automatic serve(input int f);
    door_open = 1'b1;
    sb_q.push_back(4'(f));
    step();
    n_compared++;
    if (pending[f] !== 1'b0) begin
      $display("FAIL serve_clear_%0d: got %0b expected 0", f, pending[f]);
      n_mismatch++;
    end
    door_open = 1'b0;
    step();
    n_compared++;
    if (call_served !== 1'b0) begin
      $display("FAIL served_one_cycle_%0d: got %0b expected 0", f, call_served);
      n_mismatch++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; call_btn = '0; car_floor = 4'd0;
    door_open = 1'b0; rescue = 1'b0; over_weight = 1'b0;
    repeat (3) step();
    n_compared++;
    if ({idle, requested_floor, pending, dir_up, dir_down, call_served, served_floor} !==
        {1'b1, 4'd0, 10'd0, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      $display("FAIL reset_state: idle=%0b req=%0d pend=%0h up=%0b dn=%0b cs=%0b sf=%0d expected 1/0/0/0/0/0/0",
               idle, requested_floor, pending, dir_up, dir_down, call_served, served_floor);
      n_mismatch++;
    end
    reset = 1'b1;
  endtask

  task automatic test_single_call();
    car_floor = 4'd2;
    step();
    press(5);
    n_compared++;
    if (pending !== 10'b00_0010_0000) begin
      $display("FAIL single_pending: got %0h expected 020", pending);
      n_mismatch++;
    end
    step();
    n_compared++;
    if ({requested_floor, dir_up, dir_down, idle} !== {4'd5, 1'b1, 1'b0, 1'b0}) begin
      $display("FAIL single_target: req=%0d up=%0b dn=%0b idle=%0b expected 5/1/0/0",
               requested_floor, dir_up, dir_down, idle);
      n_mismatch++;
    end
    car_floor = 4'd5;
    step();
    serve(5);
    n_compared++;
    if ({pending, idle, served_floor} !== {10'd0, 1'b1, 4'd5}) begin
      $display("FAIL single_done: pend=%0h idle=%0b sf=%0d expected 0/1/5", pending, idle, served_floor);
      n_mismatch++;
    end
  endtask

  task automatic test_scan_order();
    car_floor = 4'd4;
    step();
    press(7);
    step();
    press(2);
    step();
    n_compared++;
    if ({requested_floor, dir_up} !== {4'd7, 1'b1}) begin
      $display("FAIL scan_first: req=%0d up=%0b expected 7/1", requested_floor, dir_up);
      n_mismatch++;
    end
    car_floor = 4'd7;
    step();
    serve(7);
    n_compared++;
    if ({requested_floor, dir_up, dir_down} !== {4'd2, 1'b0, 1'b1}) begin
      $display("FAIL scan_reverse: req=%0d up=%0b dn=%0b expected 2/0/1", requested_floor, dir_up, dir_down);
      n_mismatch++;
    end
    car_floor = 4'd2;
    step();
    serve(2);
    n_compared++;
    if ({idle, dir_down} !== {1'b1, 1'b0}) begin
      $display("FAIL scan_idle: idle=%0b dn=%0b expected 1/0", idle, dir_down);
      n_mismatch++;
    end
  endtask

  task automatic test_nearer_insert();
    car_floor = 4'd3;
    step();
    press(8);
    step();
    n_compared++;
    if (requested_floor !== 4'd8) begin
      $display("FAIL nearer_initial: got %0d expected 8", requested_floor);
      n_mismatch++;
    end
    press(5);
    n_compared++;
    if ({pending[5], requested_floor} !== {1'b1, 4'd8}) begin
      $display("FAIL nearer_one_edge: pend5=%0b req=%0d expected 1/8", pending[5], requested_floor);
      n_mismatch++;
    end
    step();
    n_compared++;
    if (requested_floor !== 4'd5) begin
      $display("FAIL nearer_target: got %0d expected 5", requested_floor);
      n_mismatch++;
    end
    do_reset();
    n_compared++;
    if ({pending, requested_floor, dir_up, idle} !== {10'd0, 4'd0, 1'b0, 1'b1}) begin
      $display("FAIL mid_reset: pend=%0h req=%0d up=%0b idle=%0b expected 0/0/0/1",
               pending, requested_floor, dir_up, idle);
      n_mismatch++;
    end
  endtask

  task automatic test_freeze();
    car_floor = 4'd6;
    step();
    press(9);
    step();
    rescue = 1'b1;
    step();
    n_compared++;
    if ({requested_floor, dir_up, dir_down, idle} !== {4'd6, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL hold_entry: req=%0d up=%0b dn=%0b idle=%0b expected 6/0/0/0",
               requested_floor, dir_up, dir_down, idle);
      n_mismatch++;
    end
    press(1);
    n_compared++;
    if (pending !== 10'b10_0000_0010) begin
      $display("FAIL hold_capture: got %0h expected 202", pending);
      n_mismatch++;
    end
    rescue = 1'b0;
    step();
    n_compared++;
    if ({requested_floor, dir_up} !== {4'd6, 1'b0}) begin
      $display("FAIL hold_exit: req=%0d up=%0b expected 6/0", requested_floor, dir_up);
      n_mismatch++;
    end
    step();
    n_compared++;
    if ({requested_floor, dir_up} !== {4'd9, 1'b1}) begin
      $display("FAIL hold_resume: req=%0d up=%0b expected 9/1", requested_floor, dir_up);
      n_mismatch++;
    end
    over_weight = 1'b1;
    step();
    n_compared++;
    if ({requested_floor, dir_up} !== {4'd6, 1'b0}) begin
      $display("FAIL overweight_hold: req=%0d up=%0b expected 6/0", requested_floor, dir_up);
      n_mismatch++;
    end
    over_weight = 1'b0;
    step();
    step();
    n_compared++;
    if (requested_floor !== 4'd9) begin
      $display("FAIL overweight_resume: got %0d expected 9", requested_floor);
      n_mismatch++;
    end
    do_reset();
  endtask

  task automatic test_press_and_serve();
    car_floor = 4'd3;
    press(3);
    step();
    n_compared++;
    if ({pending[3], requested_floor} !== {1'b1, 4'd3}) begin
      $display("FAIL at_car_call: pend3=%0b req=%0d expected 1/3", pending[3], requested_floor);
      n_mismatch++;
    end
    call_btn[3] = 1'b1;
    door_open = 1'b1;
    sb_q.push_back(4'd3);
    step();
    n_compared++;
    if (pending[3] !== 1'b0) begin
      $display("FAIL clear_wins: got %0b expected 0", pending[3]);
      n_mismatch++;
    end
    call_btn[3] = 1'b0;
    door_open = 1'b0;
    step();
    n_compared++;
    if ({pending, idle} !== {10'd0, 1'b1}) begin
      $display("FAIL clear_wins_idle: pend=%0h idle=%0b expected 0/1", pending, idle);
      n_mismatch++;
    end
  endtask

  task automatic test_cancel();
    car_floor = 4'd0;
    step();
    press(7);
    step();
    press(7);
`ifdef CALL_CANCEL_EN
    n_compared++;
    if (pending[7] !== 1'b0) begin
      $display("FAIL cancel_clear: got %0b expected 0", pending[7]);
      n_mismatch++;
    end
    step();
    n_compared++;
    if ({requested_floor, idle} !== {4'd0, 1'b1}) begin
      $display("FAIL cancel_retarget: req=%0d idle=%0b expected 0/1", requested_floor, idle);
      n_mismatch++;
    end
`else
    n_compared++;
    if (pending[7] !== 1'b1) begin
      $display("FAIL repress_ignored: got %0b expected 1", pending[7]);
      n_mismatch++;
    end
    step();
    n_compared++;
    if (requested_floor !== 4'd7) begin
      $display("FAIL repress_target: got %0d expected 7", requested_floor);
      n_mismatch++;
    end
`endif
    do_reset();
  endtask

  task automatic test_out_of_range();
    car_floor = 4'd2;
    press(2);
    car_floor = 4'd12;
    door_open = 1'b1;
    step();
    door_open = 1'b0;
    step();
    n_compared++;
    if ({pending, call_served} !== {10'b00_0000_0100, 1'b0}) begin
      $display("FAIL out_of_range: pend=%0h cs=%0b expected 004/0", pending, call_served);
      n_mismatch++;
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    car_floor = 4'd4;
    call_btn[4] = 1'b1;
    step();
    door_open = 1'b1;
    sb_q.push_back(4'd4);
    step();
    door_open = 1'b0;
    repeat (3) step();
    n_compared++;
    if (pending[4] !== 1'b0) begin
      $display("FAIL held_no_retrigger: got %0b expected 0", pending[4]);
      n_mismatch++;
    end
    call_btn[4] = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_scan_order();
    test_nearer_insert();
    test_freeze();
    test_press_and_serve();
    test_cancel();
    test_out_of_range();
    test_back_to_back();
    step();
    n_compared++;
    if (sb_q.size() != 0) begin
      $display("FAIL served_outstanding: got %0d pending serves expected 0", sb_q.size());
      n_mismatch++;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/floor_request_dispatcher.md
# floor_request_dispatcher

Collects floor call-button presses, latches them as pending calls, and drives `requested_floor` into the elevator controller one target at a time using SCAN ordering: finish the current direction, then reverse. It sits between the car/hall button panel and the elevator controller. It watches the controller's `current_floor_reg` and `open_door` outputs to retire served calls.

## Interface
- `NUM_FLOORS`, default 10: number of floors, 0..NUM_FLOORS-1. Legal range 2..16.
- `FLOOR_W`, default 4: floor-number width. Must satisfy 2^FLOOR_W ≥ NUM_FLOORS.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-low reset.
- `call_btn`  in  NUM_FLOORS  level button inputs, one per floor, synchronous to `clk`.
- `car_floor`  in  FLOOR_W  car position, from the controller's current floor register.
- `door_open`  in  1  controller door-open status.
- `rescue`  in  1  controller rescue request; freezes dispatch.
- `over_weight`  in  1  overload; freezes dispatch.
- `requested_floor`  out  FLOOR_W  target floor to the controller.
- `pending`  out  NUM_FLOORS  latched calls; also the button lamps.
- `dir_up`, `dir_down`  out  1 each  committed travel direction; never both high.
- `idle`  out  1  no calls pending and state IDLE.
- `call_served`  out  1  one-cycle pulse when a call is retired.
- `served_floor`  out  FLOOR_W  floor retired with the last `call_served`; held between pulses.

## Operation
- **Call capture**
  - `call_btn` is registered; a rising edge on bit i sets `pending[i]`.
  - Held buttons do not re-trigger.
- **Call retirement**
  - `door_open` is registered to detect its rising edge.
  - On a `door_open` rising edge with `car_floor` < NUM_FLOORS and `pending[car_floor]` set:
    - clear `pending[car_floor]`;
    - pulse `call_served`;
    - load `served_floor` with `car_floor`.
  - If a set and a clear for the same floor fall in the same cycle, the clear wins.
  - Out-of-range `car_floor` never clears anything.
- **States: IDLE, UP, DOWN, HOLD.**
  - **IDLE:**
    - If `pending[car_floor]` is set: target = `car_floor`, stay in IDLE.
    - Else if any call is pending above `car_floor`: go to UP.
    - Else if any call is pending below: go to DOWN.
    - Else: target = `car_floor`.
  - **UP:**
    - Target = lowest pending floor ≥ `car_floor`.
    - If none exists: go to DOWN when a call is pending below, otherwise go to IDLE.
  - **DOWN:**
    - Target = highest pending floor ≤ `car_floor`.
    - If none exists: go to UP when a call is pending above, otherwise go to IDLE.
  - **HOLD:**
    - Entered from any state while `rescue` or `over_weight` is high. Both have priority over all other transitions.
    - Target = `car_floor` (stops the car).
    - Calls are still captured and retired.
    - Exits to IDLE on the first cycle with both inputs low.
- **Direction outputs:** `dir_up` = (state==UP), `dir_down` = (state==DOWN).
- **`idle`:** (state==IDLE) && (`pending`==0).
- **Targeting a new call:** a call inserted ahead of the car in the current direction becomes the target if it is nearer. Calls behind the car wait for reversal.

## Timing
- **Reset values:**
  - state IDLE;
  - `pending` = 0;
  - `requested_floor` = 0;
  - `dir_up` = `dir_down` = 0;
  - `idle` = 1;
  - `call_served` = 0;
  - `served_floor` = 0;
  - edge-detect registers = 0.
- **Reset mid-operation:** reset asserted on any cycle discards all pending calls. Outputs take their reset values on the next edge.
- **Call capture latency:** `call_btn[i]` rises in cycle n → `pending[i]` is high after edge n+1.
- **Target latency:** `requested_floor`, state and direction update one edge after the `pending`/`car_floor` change that causes them. A press therefore reaches `requested_floor` 2 edges after the button rises.
- **Retirement latency:** `door_open` rises in cycle n → `pending` bit cleared and `call_served` high for exactly one cycle after edge n+1.
- **HOLD entry:** `rescue` or `over_weight` high in cycle n → state HOLD and `requested_floor` = `car_floor` after edge n+1.
- All outputs are registered.

## Configuration
- **Macro `CALL_CANCEL_EN`.**
  - **Defined:** a rising edge on `call_btn[i]` while `pending[i]` is already set clears `pending[i]`. No `call_served` pulse is generated. If floor i was the target, the target is recomputed on the next edge.
  - **Undefined:** re-presses of a lit button are ignored.

## Test plan
- **Reset, no calls:** reset low 3 cycles, `car_floor`=0 → `idle`=1, `requested_floor`=0, `pending`=0.
- **Single call above:** `car_floor`=2, press floor 5 → `pending`[5]=1, then state UP, `requested_floor`=5, `dir_up`=1. Then `car_floor`=5 and `door_open` rises → `call_served` 1 cycle, `served_floor`=5, `pending`=0, `idle`=1.
- **SCAN order:** car at 4 in UP with calls at 7 and 2 → target 7 first. After 7 is served, state goes to DOWN and target = 2.
- **Nearer insertion:** car at 3 heading to 8, press 5 → `requested_floor` becomes 5 two edges after the press.
- **Freeze:** `rescue`=1 while car at 6 heading to 9 → HOLD, `requested_floor`=6. Press 1 → `pending`[1] still set. Release `rescue` → IDLE, then target resumes at 9 (UP, since a call is above).
- **Simultaneous press and serve, and cancel:**
  - Press floor 3 in the same cycle as the `door_open` edge at floor 3 → `pending`[3]=0.
  - With `CALL_CANCEL_EN` defined, second press of floor 7 → `pending`[7]=0, no `call_served` pulse.
